// File: rtl/gemips_pipe_pkg.sv
// Shared definitions for the GeMIPS pipeline stall/flush controller.
// Contents: stage index constants, controller state encoding, the
// stall/flush vector pair carried as a packed struct, and the fixed
// vector pairs for each request class.
package gemips_pipe_pkg;

    localparam int unsigned STAGE_N = 6;

    // Bit positions inside the stall/flush vectors
    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned WAIT_W = 8;

    typedef logic [STAGE_N-1:0] stage_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_HOLD = 3'd1,
        ST_EXC_FLUSH = 3'd2
    } state_t;

    typedef struct packed {
        stage_vec_t stall;
        stage_vec_t flush;
    } ctrl_vec_t;

    // Vector pairs per winning request, listed highest priority first
    localparam ctrl_vec_t VEC_EXC       = '{stall: 6'b000000, flush: 6'b011110};
    localparam ctrl_vec_t VEC_EXC_FLUSH = '{stall: 6'b000000, flush: 6'b000010};
    localparam ctrl_vec_t VEC_MEM       = '{stall: 6'b011111, flush: 6'b100000};
    localparam ctrl_vec_t VEC_EX        = '{stall: 6'b001111, flush: 6'b010000};
    localparam ctrl_vec_t VEC_LOAD      = '{stall: 6'b000111, flush: 6'b001000};
    localparam ctrl_vec_t VEC_NONE      = '{stall: 6'b000000, flush: 6'b000000};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, clr (sync clear, wins over inc), inc (count enable),
//        cnt (current value, holds at all-ones).
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up, sticking at all-ones
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage GeMIPS pipeline.
// Arbitrates exception, MEM data wait, EX multi-cycle busy and ID load-use
// hazard into per-stage hold (stall) and bubble (flush) vectors, and keeps a
// saturating count of cycles in which the PC is held.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_stallreq         load-use hazard in ID
//   ex_stallreq         EX busy (level)
//   mem_req, mem_ack    MEM outstanding access / completion
//   exc_req             exception committed at MEM
//   stall[5:0]          hold enables (combinational)
//   flush[5:0]          bubble inserts (combinational)
//   exc_redirect        registered pulse: load PC with exception vector
//   stall_cnt           registered saturating stall-cycle count
//   mem_timeout         registered pulse on forced MEM release
// Optional: define GEMIPS_MEM_TIMEOUT_EN to bound MEM waits at MEM_TIMEOUT.
module pipe_stall_ctrl
    import gemips_pipe_pkg::*;
#(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_stallreq,
    input  logic                ex_stallreq,
    input  logic                mem_req,
    input  logic                mem_ack,
    input  logic                exc_req,
    output logic [STAGE_N-1:0]  stall,
    output logic [STAGE_N-1:0]  flush,
    output logic                exc_redirect,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic                mem_timeout
);

    // Elaboration-time parameter range checks
    if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 15) begin : g_bad_load_bubbles
        $error("LOAD_BUBBLES must be in 1..15");
    end
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_mem_timeout
        $error("MEM_TIMEOUT must be in 1..255");
    end

    state_t              state;
    state_t              state_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_cnt_next;
    ctrl_vec_t           vec;
    logic                raw_wait;
    logic                mem_wait;
    logic                load_req;

    assign raw_wait = mem_req && !mem_ack;

`ifdef GEMIPS_MEM_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    // A wait cycle that reaches the limit is treated as if it were acked
    assign timeout_hit = raw_wait && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
    assign mem_wait    = raw_wait && !timeout_hit;

    // Consecutive-wait counter and the one-cycle release pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            mem_timeout <= timeout_hit;
            if (!raw_wait || timeout_hit) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end
`else
    assign mem_wait    = raw_wait;
    assign mem_timeout = 1'b0;
`endif

    // State register and registered exception redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            exc_redirect <= 1'b0;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_cnt_next;
            exc_redirect <= (state_next == ST_EXC_FLUSH);
        end
    end

    // Priority arbitration and next-state logic
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        vec           = VEC_NONE;
        load_req      = (state == ST_LOAD_HOLD) || ((state == ST_IDLE) && id_stallreq);

        if (exc_req) begin
            vec           = VEC_EXC;
            state_next    = ST_EXC_FLUSH;
            hold_cnt_next = '0;
        end else if (state == ST_EXC_FLUSH) begin
            // Everything older was just flushed; only the stale IF fetch remains
            vec        = VEC_EXC_FLUSH;
            state_next = ST_IDLE;
        end else if (mem_wait) begin
            vec = VEC_MEM;
        end else if (ex_stallreq) begin
            vec = VEC_EX;
        end else if (load_req) begin
            vec = VEC_LOAD;
            if (state == ST_LOAD_HOLD) begin
                if (hold_cnt == HOLD_W'(1)) begin
                    state_next    = ST_IDLE;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt - HOLD_W'(1);
                end
            end else if (LOAD_BUBBLES > 1) begin
                // First bubble is this cycle; the rest are counted in LOAD_HOLD
                state_next    = ST_LOAD_HOLD;
                hold_cnt_next = HOLD_W'(LOAD_BUBBLES - 1);
            end
        end
    end

    assign stall = vec.stall;
    assign flush = vec.flush;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (stall[STG_PC]),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed request sequences, a cycle model of the
// arbitration rules checked every cycle, plus literal expectations.
module tb_pipe_stall_ctrl;

    localparam int unsigned LB = 3;
    localparam int unsigned MT = 4;
    localparam int unsigned CW = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_stallreq = 1'b0;
    logic ex_stallreq = 1'b0;
    logic mem_req = 1'b0;
    logic mem_ack = 1'b0;
    logic exc_req = 1'b0;
    logic [5:0]    stall;
    logic [5:0]    flush;
    logic          exc_redirect;
    logic [CW-1:0] stall_cnt;
    logic          mem_timeout;

    int checks = 0;
    int passed = 0;

    pipe_stall_ctrl #(
        .LOAD_BUBBLES (LB),
        .MEM_TIMEOUT  (MT),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_stallreq  (id_stallreq),
        .ex_stallreq  (ex_stallreq),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .exc_req      (exc_req),
        .stall        (stall),
        .flush        (flush),
        .exc_redirect (exc_redirect),
        .stall_cnt    (stall_cnt),
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model state: remaining bubbles of a load-use, exception-flush cycle pending
    bit         valid = 1'b0;
    int         load_left = 0;
    bit         in_exc = 1'b0;
    bit         m_redirect = 1'b0;
    int         m_cnt = 0;
    int         waits = 0;
    bit         m_tout = 1'b0;
    logic [5:0] es;
    logic [5:0] ef;
    bit         mwait;
    bit         tout_hit;
    bit         load_win;

    // Inputs are stable from just after posedge until the next posedge, so the
    // negedge sees this cycle's inputs; compare, then advance the model.
    always @(negedge clk) begin
        mwait    = mem_req && !mem_ack;
        tout_hit = 1'b0;
        load_win = 1'b0;
`ifdef GEMIPS_MEM_TIMEOUT_EN
        if (mwait && waits == int'(MT)) begin
            tout_hit = 1'b1;
            mwait    = 1'b0;
        end
`endif
        if (exc_req) begin
            es = 6'b000000; ef = 6'b011110;
        end else if (in_exc) begin
            es = 6'b000000; ef = 6'b000010;
        end else if (mwait) begin
            es = 6'b011111; ef = 6'b100000;
        end else if (ex_stallreq) begin
            es = 6'b001111; ef = 6'b010000;
        end else if (load_left > 0 || id_stallreq) begin
            es = 6'b000111; ef = 6'b001000;
            load_win = 1'b1;
        end else begin
            es = 6'b000000; ef = 6'b000000;
        end

        if (valid) begin
            check("model_stall", 32'(stall), 32'(es));
            check("model_flush", 32'(flush), 32'(ef));
            check("model_exc_redirect", 32'(exc_redirect), 32'(m_redirect));
            check("model_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
            check("model_mem_timeout", 32'(mem_timeout), 32'(m_tout));
        end

        if (rst) begin
            valid      = 1'b1;
            load_left  = 0;
            in_exc     = 1'b0;
            m_redirect = 1'b0;
            m_cnt      = 0;
            waits      = 0;
            m_tout     = 1'b0;
        end else begin
            if (es[0] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            m_redirect = exc_req;
            m_tout     = tout_hit;
            waits      = (mem_req && !mem_ack && !tout_hit) ? waits + 1 : 0;
            if (exc_req) begin
                in_exc    = 1'b1;
                load_left = 0;
            end else if (in_exc) begin
                in_exc = 1'b0;
            end else if (load_win) begin
                load_left = (load_left == 0) ? int'(LB) - 1 : load_left - 1;
            end
        end
    end

    // Apply one cycle of inputs, then return mid-cycle for literal checks
    task automatic step(input bit r, input bit id, input bit ex, input bit mr,
                        input bit ma, input bit ex_c);
        @(posedge clk);
        #1;
        rst = r; id_stallreq = id; ex_stallreq = ex;
        mem_req = mr; mem_ack = ma; exc_req = ex_c;
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset_dut();
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_cnt", 32'(stall_cnt), 32'h0);
        check("rst_redirect", 32'(exc_redirect), 32'h0);

        // Single load-use pulse: exactly LB cycles of load hold
        step(0, 1, 0, 0, 0, 0);
        check("load_t0_stall", 32'(stall), 32'h07);
        check("load_t0_flush", 32'(flush), 32'h08);
        step(0, 0, 0, 0, 0, 0);
        check("load_t1_stall", 32'(stall), 32'h07);
        step(0, 0, 0, 0, 0, 0);
        check("load_t2_stall", 32'(stall), 32'h07);
        step(0, 0, 0, 0, 0, 0);
        check("load_end_stall", 32'(stall), 32'h0);
        check("load_cnt", 32'(stall_cnt), 32'd3);

        // Mem wait interrupts a load hold; hold resumes afterwards
        reset_dut();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("memld_stall", 32'(stall), 32'h1f);
        check("memld_flush", 32'(flush), 32'h20);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("memld_resume", 32'(stall), 32'h07);
        step(0, 0, 0, 0, 0, 0);
        check("memld_resume2", 32'(stall), 32'h07);
        step(0, 0, 0, 0, 0, 0);
        check("memld_end", 32'(stall), 32'h0);
        check("memld_cnt", 32'(stall_cnt), 32'd5);

        // Same-cycle request and ack: no stall
        step(0, 0, 0, 1, 1, 0);
        check("memack_stall", 32'(stall), 32'h0);

        // Exception while EX is busy
        reset_dut();
        step(0, 0, 1, 0, 0, 0);
        check("ex_stall", 32'(stall), 32'h0f);
        check("ex_flush", 32'(flush), 32'h10);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        check("exc_stall", 32'(stall), 32'h0);
        check("exc_flush", 32'(flush), 32'h1e);
        step(0, 0, 0, 0, 0, 0);
        check("excf_redirect", 32'(exc_redirect), 32'h1);
        check("excf_flush", 32'(flush), 32'h02);
        step(0, 0, 0, 0, 0, 0);
        check("exc_done_redirect", 32'(exc_redirect), 32'h0);
        check("exc_done_flush", 32'(flush), 32'h0);
        check("exc_cnt", 32'(stall_cnt), 32'd2);

        // Exception abandons a load hold
        reset_dut();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("exc_abandon_stall", 32'(stall), 32'h0);

        // Back-to-back exceptions, then EX freezing a load hold
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("exc_reserve_flush", 32'(flush), 32'h1e);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("exfreeze_resume", 32'(stall), 32'h07);
        step(0, 0, 0, 0, 0, 0);
        check("exfreeze_end", 32'(stall), 32'h0);

        // Reset in the middle of a load hold drops the stall next cycle
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("midrst_stall", 32'(stall), 32'h0);
        check("midrst_cnt", 32'(stall_cnt), 32'h0);

`ifdef GEMIPS_MEM_TIMEOUT_EN
        // Bounded MEM wait
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0, 0);
            check("tout_wait_stall4", 32'(stall[4]), 32'h1);
        end
        step(0, 0, 0, 1, 0, 0);
        check("tout_release_stall", 32'(stall), 32'h0);
        check("tout_release_pulse", 32'(mem_timeout), 32'h0);
        step(0, 0, 0, 1, 0, 0);
        check("tout_pulse", 32'(mem_timeout), 32'h1);
        step(0, 0, 0, 0, 0, 0);
        check("tout_pulse_end", 32'(mem_timeout), 32'h0);
`endif

        // Counter saturation with a long EX busy period
        reset_dut();
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0);
        check("sat_cnt_9", 32'(stall_cnt), 32'd9);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0);
        check("sat_cnt_15", 32'(stall_cnt), 32'd15);
        step(0, 0, 0, 0, 0, 0);
        check("sat_hold", 32'(stall_cnt), 32'd15);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage GeMIPS pipeline. Replaces the fixed-length IF stall with handshake-driven sequencing.
- Arbitrates four requests into per-stage stall and flush (bubble) vectors:
  - ID load-use hazard
  - EX multi-cycle op
  - MEM data-bus wait
  - MEM exception
- Sits beside the pipeline registers and drives their hold/clear inputs.
- Also keeps a stall-cycle performance counter.

Parameters:
LOAD_BUBBLES, 1, number of stall cycles per load-use hazard, legal range 1..15
MEM_TIMEOUT, 255, max consecutive MEM wait cycles before forced release (only with the optional feature), legal range 1..255
CNT_W, 32, width of the stall performance counter

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, synchronous, active-high
id_stallreq  input  1  load-use hazard detected in ID
ex_stallreq  input  1  EX busy with multi-cycle op (mult/div); level, held until done
mem_req  input  1  MEM stage has an outstanding data access
mem_ack  input  1  data access completes this cycle
exc_req  input  1  exception committed at MEM this cycle
stall  output  6  hold enables [0]=PC [1]=IF/ID [2]=ID/EX-src [3]=EX [4]=MEM [5]=WB
flush  output  6  bubble insert into the register feeding stage bit
exc_redirect  output  1  load PC with exception vector
stall_cnt  output  CNT_W  saturating count of cycles with stall[0]=1
mem_timeout  output  1  MEM wait aborted (optional feature)

Behaviour:
- Reset values: stall=0, flush=0, exc_redirect=0, stall_cnt=0, mem_timeout=0, state=IDLE, hold_cnt=0, wait_cnt=0. Reset mid-stall drops all stalls next cycle.
- stall and flush are combinational from the current state and inputs, so a request in cycle N affects cycle N. exc_redirect, stall_cnt and mem_timeout are registered.
- Invariant: if stall[k]=1 then stall[j]=1 for all j<k. At most one flush bit is set above the highest stall bit, except during an exception.
- Priority in every cycle, highest first:
  1. exc_req: stall=000000, flush=011110.
  2. Mem wait (mem_req && !mem_ack): stall=011111, flush=100000.
  3. ex_stallreq: stall=001111, flush=010000.
  4. Load hold (id_stallreq in IDLE, or state LOAD_HOLD): stall=000111, flush=001000.
  5. Otherwise: stall=0, flush=0.
- States:
  - IDLE:
    - exc_req -> EXC_FLUSH.
    - Load-use win when LOAD_BUBBLES>1: load hold_cnt=LOAD_BUBBLES-1, go to LOAD_HOLD.
    - Load-use win when LOAD_BUBBLES==1: stay in IDLE; the stall lasts exactly 1 cycle.
  - LOAD_HOLD:
    - Asserts the load hold regardless of id_stallreq.
    - In cycles where the load hold is the winning request: hold_cnt decrements; hold_cnt==1 -> IDLE.
    - When mem wait or ex_stallreq wins: hold_cnt is frozen and the higher-priority vectors are output.
    - exc_req -> EXC_FLUSH and the hold is abandoned.
  - EXC_FLUSH (1 cycle): exc_redirect=1 (registered pulse), flush=000010 so the IF fetch from the old PC is discarded. Then -> IDLE. exc_req here is re-served (stays in EXC_FLUSH).
- Total load-use stall = exactly LOAD_BUBBLES cycles in which the load hold wins.
- mem_req && mem_ack in the same cycle gives no stall.
- stall_cnt increments when stall[0]=1 and saturates at all-ones. It is not cleared by exceptions.

Optional Feature:
- Macro: GEMIPS_MEM_TIMEOUT_EN.
- Defined:
  - 8-bit wait_cnt increments on each mem-wait cycle and clears on mem_ack or !mem_req.
  - When wait_cnt==MEM_TIMEOUT in a wait cycle, that cycle is treated as acked: no mem stall.
  - mem_timeout pulses 1 on the following cycle and wait_cnt clears.
- Undefined: no wait_cnt, mem_timeout tied 0, waits are unbounded.

Decomposition:
- Package gemips_pipe_pkg:
  - stage index constants (PC, IF, ID, EX, MEM, WB), STAGE_N=6
  - the 3-bit state encoding (IDLE, LOAD_HOLD, EXC_FLUSH)
  - the canned stall/flush vectors per request class
- One sub-module: sat_counter (parameterised width, inc enable, sync clear), used for stall_cnt.

Test Plan:
- rst=1 for 2 cycles, all requests 0 -> stall=0, flush=0, stall_cnt=0, state IDLE.
- LOAD_BUBBLES=3, id_stallreq pulsed 1 cycle -> stall=000111, flush=001000 for exactly 3 cycles, then 0; stall_cnt=3.
- LOAD_BUBBLES=3, id_stallreq at t0, mem_req=1/mem_ack=0 at t1..t2 -> stall=011111 at t1..t2; load hold resumes t3..t4; total 5 stalled cycles, stall_cnt=5.
- exc_req asserted during ex_stallreq -> that cycle stall=0, flush=011110; next cycle exc_redirect=1, flush=000010; then IDLE.
- GEMIPS_MEM_TIMEOUT_EN, MEM_TIMEOUT=4, mem_req=1, mem_ack=0 held -> stall[4]=1 for 4 cycles, released on the 5th; mem_timeout=1 on the 6th for one cycle.
- stall_cnt preloaded via long ex_stallreq with CNT_W=4 -> counts to 15 and holds at 15.
